// File: rtl/spi_cmd_seq_if.sv
// spi_cmd_seq_if: command/response streams plus the spi_top register port,
// seen from the sequencer (slave) and from its driver (master).
interface spi_cmd_seq_if;
  logic [7:0] cfg_ctrl;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [2:0] cmd_ss;
  logic       cmd_last;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [1:0] addr;
  logic       wr;
  logic [7:0] data_wr;
  logic [7:0] data_rd;
  modport slave (
    input  cfg_ctrl, cmd_valid, cmd_data, cmd_ss, cmd_last, rsp_ready, data_rd,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, addr, wr, data_wr
  );
  modport master (
    output cfg_ctrl, cmd_valid, cmd_data, cmd_ss, cmd_last, rsp_ready, data_rd,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, addr, wr, data_wr
  );
endinterface

// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: runs one byte transfer per command through the spi_top register
// port, holding slave select across bursts and aborting a stuck transfer.
module spi_cmd_seq #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_cmd_seq_if.slave  bus
);
  typedef enum logic [3:0] {IDLE, WR_CFG, WR_SS, WR_TX, WR_START, POLL, RD_RX, ERR, DESEL, RSP} state_t;
  state_t state, state_n;
  logic [7:0] cfg_q, data_q, rsp_data, data_wr;
  logic [2:0] ss_q;
  logic [1:0] addr;
  logic [TO_W-1:0] cnt;
  logic last_q, burst, run, rsp_err, wr, hs;
  // run keeps cmd_ready low while reset is held and until the first clock after it
  assign hs            = bus.cmd_valid & bus.cmd_ready;
  assign bus.cmd_ready = run & (state == IDLE);
  assign bus.rsp_valid = state == RSP;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;
  assign bus.addr      = addr;
  assign bus.wr        = wr;
  assign bus.data_wr   = data_wr;
  always_comb begin
    state_n = state;
    addr    = 2'd0;
    wr      = 1'b0;
    data_wr = 8'h00;
    case (state)
      IDLE:     state_n = hs ? (burst ? WR_TX : WR_CFG) : IDLE;
      WR_CFG:   begin wr = 1'b1; addr = 2'd0; data_wr = cfg_q; state_n = WR_SS; end
      WR_SS:    begin wr = 1'b1; addr = 2'd2; data_wr = ~(8'h01 << ss_q); state_n = WR_TX; end
      WR_TX:    begin wr = 1'b1; addr = 2'd1; data_wr = data_q; state_n = WR_START; end
      WR_START: begin wr = 1'b1; addr = 2'd3; data_wr = 8'h01; state_n = POLL; end
      POLL: begin
        addr    = 2'd3;
        state_n = bus.data_rd[0] ? RD_RX : (cnt == TO_W'(TIMEOUT - 1)) ? ERR : POLL;
      end
      RD_RX:    begin addr = 2'd1; state_n = last_q ? DESEL : RSP; end
      ERR:      state_n = DESEL;
      DESEL:    begin wr = 1'b1; addr = 2'd2; data_wr = 8'hFF; state_n = RSP; end
      RSP:      state_n = bus.rsp_ready ? IDLE : RSP;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      run      <= 1'b0;
      burst    <= 1'b0;
      cfg_q    <= 8'h00;
      data_q   <= 8'h00;
      ss_q     <= 3'd0;
      last_q   <= 1'b0;
      cnt      <= '0;
      rsp_data <= 8'h00;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_n;
      run   <= 1'b1;
      if (state == IDLE && hs) begin
        data_q <= bus.cmd_data;
        last_q <= bus.cmd_last;
        if (!burst) begin
          cfg_q <= bus.cfg_ctrl;
          ss_q  <= bus.cmd_ss;
        end
      end
      if (state == WR_SS) burst <= 1'b1;
      if (state == DESEL) burst <= 1'b0;
      if (state == WR_START) cnt <= '0;
      if (state == POLL) cnt <= (cnt == TO_W'(TIMEOUT)) ? cnt : cnt + 1'b1;
      if (state == RD_RX) begin
        rsp_data <= bus.data_rd;
        rsp_err  <= 1'b0;
      end
      if (state == ERR) begin
        rsp_data <= 8'h00;
        rsp_err  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_cmd_seq.sv
// tb_spi_cmd_seq: directed vectors against a small spi_top register model
// that logs every register write.
module tb_spi_cmd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_cmd_seq_if bus();
  spi_cmd_seq #(.TIMEOUT(16), .TO_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [15:0] wlog[$];
  logic [7:0] m_ss, m_rx, rx_val;
  logic m_end;
  int m_busy;
  bit stuck = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ss   <= 8'hFF;
      m_rx   <= 8'h00;
      m_end  <= 1'b0;
      m_busy <= 0;
    end else if (bus.wr) begin
      wlog.push_back({6'b0, bus.addr, bus.data_wr});
      if (bus.addr == 2'd2) m_ss <= bus.data_wr;
      if (bus.addr == 2'd3 && bus.data_wr[0]) begin
        m_end  <= 1'b0;
        m_busy <= stuck ? 0 : 3;
      end
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_end <= 1'b1;
        m_rx  <= rx_val;
      end
    end
  end
  assign bus.data_rd = bus.addr == 2'd1 ? m_rx : bus.addr == 2'd3 ? {7'b0, m_end} :
                       bus.addr == 2'd2 ? m_ss : 8'h00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] cfg, input logic [7:0] data, input logic [2:0] ss, input logic last);
    int n = 0;
    @(negedge clk);
    bus.cfg_ctrl  = cfg;
    bus.cmd_data  = data;
    bus.cmd_ss    = ss;
    bus.cmd_last  = last;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accepted", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic get_rsp(output logic [7:0] data, output logic err);
    int n = 0;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrived", 32'(n < 200), 32'd1);
    data = bus.rsp_data;
    err  = bus.rsp_err;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask
  typedef struct {
    logic [7:0] cfg;
    logic [7:0] data;
    logic [2:0] ss;
    logic       last;
    logic [7:0] rx;
  } vec_t;
  vec_t vt[4];
  logic [15:0] ew[15];
  logic [7:0] rd, hold;
  logic re;
  int polls, bad;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{8'h05, 8'hA5, 3'd3, 1'b1, 8'h3C};
    vt[1] = '{8'h0A, 8'h11, 3'd5, 1'b0, 8'h81};
    vt[2] = '{8'hFF, 8'h22, 3'd1, 1'b0, 8'h82};
    vt[3] = '{8'h00, 8'h33, 3'd7, 1'b1, 8'h83};
    ew = '{16'h0005, 16'h02F7, 16'h01A5, 16'h0301, 16'h02FF,
           16'h000A, 16'h02DF, 16'h0111, 16'h0301,
           16'h0122, 16'h0301,
           16'h0133, 16'h0301, 16'h02FF, 16'hFFFF};
    bus.cfg_ctrl = 8'h00; bus.cmd_valid = 1'b0; bus.cmd_data = 8'h00;
    bus.cmd_ss = 3'd0; bus.cmd_last = 1'b0; bus.rsp_ready = 1'b0;
    rx_val = 8'h00;
    #12;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_bus", {bus.addr, bus.wr, bus.data_wr, bus.rsp_err, bus.rsp_data}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    // single byte, then a 3-byte burst with a mid-burst slave/config change
    for (int i = 0; i < 4; i++) begin
      rx_val = vt[i].rx;
      send(vt[i].cfg, vt[i].data, vt[i].ss, vt[i].last);
      get_rsp(rd, re);
      chk($sformatf("vec%0d_rsp_data", i), 32'(rd), 32'(vt[i].rx));
      chk($sformatf("vec%0d_rsp_err", i), 32'(re), 32'd0);
    end
    chk("write_count", wlog.size(), 14);
    for (int i = 0; i < 14; i++)
      chk($sformatf("write%0d", i), i < wlog.size() ? 32'(wlog[i]) : 32'hDEAD, 32'(ew[i]));
    // timeout: EndTx never rises; errors deselect even without CmdLast
    wlog.delete();
    stuck = 1'b1;
    send(8'h05, 8'h44, 3'd2, 1'b0);
    polls = 0;
    for (int n = 0; n < 200 && !bus.rsp_valid; n++) begin
      @(negedge clk);
      if (bus.addr == 2'd3 && !bus.wr) polls++;
    end
    chk("timeout_poll_cycles", polls, 16);
    get_rsp(rd, re);
    chk("timeout_rsp_data", 32'(rd), 32'h00);
    chk("timeout_rsp_err", 32'(re), 32'd1);
    chk("timeout_last_write", wlog.size() > 0 ? 32'(wlog[wlog.size()-1]) : 32'hDEAD, 32'h02FF);
    chk("timeout_ss_released", 32'(m_ss), 32'hFF);
    // backpressure: response held while the burst stays selected
    stuck = 1'b0;
    rx_val = 8'h96;
    send(8'h05, 8'h55, 3'd6, 1'b0);
    for (int n = 0; n < 200 && !bus.rsp_valid; n++) @(negedge clk);
    wlog.delete();
    hold = bus.rsp_data;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data != hold || bus.cmd_ready || bus.wr) bad++;
    end
    chk("bp_rsp_data", 32'(hold), 32'h96);
    chk("bp_violations", bad, 0);
    chk("bp_no_writes", wlog.size(), 0);
    chk("bp_ss_held", 32'(m_ss), 32'hBF);
    get_rsp(rd, re);
    chk("bp_rsp_after", 32'(rd), 32'h96);
    rx_val = 8'h69;
    send(8'h05, 8'h66, 3'd0, 1'b1);
    get_rsp(rd, re);
    chk("bp_close_rsp", 32'(rd), 32'h69);
    // reset while polling
    stuck = 1'b1;
    send(8'h0C, 8'h77, 3'd4, 1'b0);
    repeat (8) @(negedge clk);
    chk("pre_rst_in_poll", {30'd0, bus.addr}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("async_rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'd0);
    chk("async_rst_bus", {bus.addr, bus.wr, bus.data_wr}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    stuck = 1'b0;
    wlog.delete();
    rx_val = 8'hC3;
    send(8'h05, 8'h5A, 3'd0, 1'b1);
    get_rsp(rd, re);
    chk("post_rst_rsp", {re, rd}, 32'h0C3);
    chk("post_rst_write0", wlog.size() > 1 ? 32'(wlog[0]) : 32'hDEAD, 32'h0005);
    chk("post_rst_write1", wlog.size() > 1 ? 32'(wlog[1]) : 32'hDEAD, 32'h02FE);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_cmd_seq.md
Name: spi_cmd_seq

Overview:
- Command sequencer directly upstream of spi_top.
- Accepts byte-transfer commands on a valid/ready stream and drives the spi_top register port (Addr/Wr/DataWr/DataRd) to run each transfer.
- Returns the received MISO byte on a response stream, so software and DMA no longer poll registers by hand.
- Manages slave-select assertion across multi-byte bursts and aborts on a stuck transfer.

Parameters:
- TIMEOUT, 1024, max cycles in POLL before abort (min 16).
- TO_W, 11, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  async active-low reset
- CfgCtrl  in  8  control word written to register 0: [0]=CPol, [1]=CPha, [5:2]=CPre; sampled at burst start
- CmdValid  in  1  command valid
- CmdReady  out  1  command accepted when CmdValid&CmdReady
- CmdData  in  8  byte to transmit
- CmdSS  in  3  slave index 0-7
- CmdLast  in  1  deselect slave after this byte
- RspValid  out  1  response valid
- RspReady  in  1  response consumed when RspValid&RspReady
- RspData  out  8  received byte (8'h00 on error)
- RspErr  out  1  transfer timed out
- Addr  out  2  to spi_top Addr
- Wr  out  1  to spi_top Wr
- DataWr  out  8  to spi_top DataWr
- DataRd  in  8  from spi_top DataRd, combinational from Addr

Behaviour:
- Register map (spi_regs), all fixed:
  - 0 = control.
  - 1 = TxData on write, RxData on read.
  - 2 = SlaveSelectors, active-low, 8'hFF = none selected.
  - 3 = write bit0=1 starts a transfer (StartTx); read bit0 = EndTx, sticky until the next start.
- Reset values: CmdReady=0, RspValid=0, RspData=0, RspErr=0, Addr=0, Wr=0, DataWr=0, burst flag=0, state IDLE.
- Register writes:
  - Every write is exactly one cycle with Wr=1 and Addr/DataWr valid.
  - Outside write states, Wr=0.
- Register reads:
  - DataRd is sampled on the clock edge ending a cycle in which Addr is driven.
- FSM states and transitions:
  - IDLE: CmdReady=1. On handshake, latch CmdData, CmdSS, CmdLast. If burst flag=0, latch CfgCtrl and go WR_CFG; else go WR_TX.
  - WR_CFG: write Addr=0, DataWr=CfgCtrl latch. Go WR_SS.
  - WR_SS: write Addr=2, DataWr=~(8'h01<<CmdSS). Set burst flag. Go WR_TX.
  - WR_TX: write Addr=1, DataWr=CmdData latch. Go WR_START.
  - WR_START: write Addr=3, DataWr=8'h01. Clear timeout counter. Go POLL.
  - POLL: Addr=3, Wr=0.
    - DataRd[0]=1 → RD_RX.
    - Else increment counter; at TIMEOUT → ERR.
  - RD_RX: Addr=1, latch RspData=DataRd, RspErr=0. Go DESEL if CmdLast, else RSP.
  - ERR: RspData=0, RspErr=1. Go DESEL; errors always deselect.
  - DESEL: write Addr=2, DataWr=8'hFF. Clear burst flag. Go RSP.
  - RSP: RspValid=1 and RspData/RspErr held stable until RspReady. Handshake → IDLE.
- Slave index within a burst:
  - While burst flag=1, a new command's CmdSS is ignored; the slave stays the one latched at burst start.
  - CfgCtrl changes mid-burst are ignored.
- Minimum command-to-response latency:
  - First byte of a burst: 6 cycles plus spi_top transfer time.
  - Continuation bytes: 4 cycles plus transfer time.
- Only one command is in flight. CmdReady=0 in every state except IDLE.
- Response backpressure: RspReady low holds RSP indefinitely. SS stays asserted, and no new command is accepted.
- Rst_n low at any time, including mid-transfer: immediate return to reset values. The SS register in spi_top is reset by its own Rst_n.
- The timeout counter saturates and never wraps. The abort fires on the cycle the count equals TIMEOUT.

Test Plan:
- Single byte: CfgCtrl=8'h05, cmd CmdData=8'hA5, CmdSS=3, CmdLast=1, model returns 8'h3C.
  - Required writes in order: (0,05), (2,F7), (1,A5), (3,01), then (2,FF) after the EndTx poll.
  - Response 8'h3C with RspErr=0.
- Burst of 3 bytes to slave 5, last byte with CmdLast=1:
  - Exactly one write of 8'hDF to register 2 and one write of 8'hFF at the end.
  - Three responses, in order.
- Mid-burst change: CmdSS=1 and CfgCtrl=8'hFF on byte 2.
  - No writes to register 0 or register 2 until burst end.
- Timeout with TIMEOUT=16, EndTx never set:
  - RspErr=1, RspData=8'h00, register 2 written 8'hFF, abort exactly 16 POLL cycles after WR_START.
- Backpressure: RspReady held low 20 cycles.
  - RspValid stays 1 with stable data, CmdReady stays 0, and no bus writes occur.
- Reset asserted while in POLL:
  - All outputs return to reset values asynchronously.
  - A following command restarts from WR_CFG.
